// File: rtl/alu_rs_bank.sv
// ALU reservation-station bank: dispatch into decoder-chosen slots,
// CDB operand capture, oldest-ready issue over a valid/ready handshake.
module alu_rs_bank #(
    parameter int NUM_ENTRIES = 3,
    parameter int ROB_ID_W    = 4,
    parameter int OP_W        = 3,
    parameter int WORD_W      = 16,
    localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   disp_valid,
    input  logic [IDX_W-1:0]       disp_idx,
    input  logic [OP_W-1:0]        disp_op,
    input  logic [ROB_ID_W-1:0]    disp_qj,
    input  logic [ROB_ID_W-1:0]    disp_qk,
    input  logic [WORD_W-1:0]      disp_vj,
    input  logic [WORD_W-1:0]      disp_vk,
    input  logic [ROB_ID_W-1:0]    disp_dest,
    output logic [NUM_ENTRIES-1:0] available,
    input  logic                   cdb_valid,
    input  logic [ROB_ID_W-1:0]    cdb_rob_id,
    input  logic [WORD_W-1:0]      cdb_value,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [OP_W-1:0]        issue_op,
    output logic [WORD_W-1:0]      issue_vj,
    output logic [WORD_W-1:0]      issue_vk,
    output logic [ROB_ID_W-1:0]    issue_dest,
    output logic [IDX_W-1:0]       issue_idx
);

    localparam logic [ROB_ID_W-1:0] INV = '1;

    logic [NUM_ENTRIES-1:0] r_busy;
    logic [OP_W-1:0]        r_op    [NUM_ENTRIES];
    logic [ROB_ID_W-1:0]    r_qj    [NUM_ENTRIES];
    logic [ROB_ID_W-1:0]    r_qk    [NUM_ENTRIES];
    logic [WORD_W-1:0]      r_vj    [NUM_ENTRIES];
    logic [WORD_W-1:0]      r_vk    [NUM_ENTRIES];
    logic [ROB_ID_W-1:0]    r_dest  [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_older [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] w_older_nxt [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_ready;
    logic [NUM_ENTRIES-1:0] w_has_older;
    logic [NUM_ENTRIES-1:0] w_sel_oh;
    logic [NUM_ENTRIES-1:0] w_disp_go;
    logic [NUM_ENTRIES-1:0] w_iss_go;
    logic                   w_cdb_ok;
    logic                   w_fwd_j;
    logic                   w_fwd_k;
    logic                   w_found;

    assign available = ~r_busy;
    assign issue_valid = |w_ready;
    assign w_cdb_ok = cdb_valid && (cdb_rob_id != INV);
    assign w_fwd_j = w_cdb_ok && (disp_qj == cdb_rob_id);
    assign w_fwd_k = w_cdb_ok && (disp_qk == cdb_rob_id);

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_ready[i] = r_busy[i] && (r_qj[i] == INV)
                         && (r_qk[i] == INV);
            w_disp_go[i] = disp_valid && !r_busy[i]
                           && (disp_idx == IDX_W'(i));
        end
    end

    // A slot wins when no older slot is also ready.
    always_comb begin
        w_has_older = '0;
        w_sel_oh    = '0;
        w_found     = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (r_older[j][i] && w_ready[j])
                    w_has_older[i] = 1'b1;
            end
            if (w_ready[i] && !w_has_older[i] && !w_found) begin
                w_sel_oh[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
        w_iss_go = issue_ready ? w_sel_oh : '0;
    end

    always_comb begin
        issue_op   = '0;
        issue_vj   = '0;
        issue_vk   = '0;
        issue_dest = '0;
        issue_idx  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_sel_oh[i]) begin
                issue_op   = r_op[i];
                issue_vj   = r_vj[i];
                issue_vk   = r_vk[i];
                issue_dest = r_dest[i];
                issue_idx  = IDX_W'(i);
            end
        end
    end

    // Issued slots drop out of the order after new arrivals are ranked.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                w_older_nxt[i][j] = r_older[i][j];
                if (w_disp_go[i])
                    w_older_nxt[i][j] = 1'b0;
                if (w_disp_go[j] && (i != j) && r_busy[i])
                    w_older_nxt[i][j] = 1'b1;
                if (w_iss_go[i] || w_iss_go[j])
                    w_older_nxt[i][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_op[i]    <= '0;
                r_qj[i]    <= INV;
                r_qk[i]    <= INV;
                r_vj[i]    <= '0;
                r_vk[i]    <= '0;
                r_dest[i]  <= '0;
                r_older[i] <= '0;
            end
        end else if (flush) begin
            r_busy <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++)
                r_older[i] <= '0;
        end else begin
            r_busy <= (r_busy & ~w_iss_go) | w_disp_go;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_older[i] <= w_older_nxt[i];
                if (w_disp_go[i]) begin
                    r_op[i]   <= disp_op;
                    r_dest[i] <= disp_dest;
                    r_qj[i]   <= w_fwd_j ? INV : disp_qj;
                    r_vj[i]   <= w_fwd_j ? cdb_value : disp_vj;
                    r_qk[i]   <= w_fwd_k ? INV : disp_qk;
                    r_vk[i]   <= w_fwd_k ? cdb_value : disp_vk;
                end else if (r_busy[i] && w_cdb_ok) begin
                    if (r_qj[i] == cdb_rob_id) begin
                        r_qj[i] <= INV;
                        r_vj[i] <= cdb_value;
                    end
                    if (r_qk[i] == cdb_rob_id) begin
                        r_qk[i] <= INV;
                        r_vk[i] <= cdb_value;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_bank.sv
// Directed bench for alu_rs_bank with a queue-based issue scoreboard.
module tb_alu_rs_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        disp_valid;
    logic [1:0]  disp_idx;
    logic [2:0]  disp_op;
    logic [3:0]  disp_qj, disp_qk;
    logic [15:0] disp_vj, disp_vk;
    logic [3:0]  disp_dest;
    logic [2:0]  available;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [15:0] cdb_value;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_op;
    logic [15:0] issue_vj, issue_vk;
    logic [3:0]  issue_dest;
    logic [1:0]  issue_idx;

    int checks = 0;
    int errors = 0;

    // {op, vj, vk, dest, idx}
    logic [40:0] exp_q[$];

    always #5 clk = ~clk;

    alu_rs_bank dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_idx(disp_idx),
        .disp_op(disp_op), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_dest(disp_dest), .available(available),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_dest(issue_dest), .issue_idx(issue_idx)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [1:0] idx, input logic [2:0] op,
                        input logic [3:0] qj, input logic [15:0] vj,
                        input logic [3:0] qk, input logic [15:0] vk,
                        input logic [3:0] dest);
        disp_valid = 1'b1;
        disp_idx   = idx;
        disp_op    = op;
        disp_qj    = qj;
        disp_vj    = vj;
        disp_qk    = qk;
        disp_vk    = vk;
        disp_dest  = dest;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic expect_issue(input logic [2:0] op,
                                input logic [15:0] vj,
                                input logic [15:0] vk,
                                input logic [3:0] dest,
                                input logic [1:0] idx);
        exp_q.push_back({op, vj, vk, dest, idx});
    endtask

    // Monitor: every accepted issue must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: dest %0h idx %0d",
                         issue_dest, issue_idx);
            end else begin
                logic [40:0] e;
                e = exp_q.pop_front();
                chk("issue_op", int'(issue_op), int'(e[40:38]));
                chk("issue_vj", int'(issue_vj), int'(e[37:22]));
                chk("issue_vk", int'(issue_vk), int'(e[21:6]));
                chk("issue_dest", int'(issue_dest), int'(e[5:2]));
                chk("issue_idx", int'(issue_idx), int'(e[1:0]));
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0;
        disp_idx = '0; disp_op = '0; disp_qj = 4'hF; disp_qk = 4'hF;
        disp_vj = '0; disp_vk = '0; disp_dest = '0;
        cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = '0;
        issue_ready = 1'b0;
        #12;
        chk("rst_avail", int'(available), 7);
        chk("rst_valid", int'(issue_valid), 0);
        chk("rst_dest", int'(issue_dest), 0);
        rst_n = 1'b1;
        tick();

        // ready-at-dispatch issues next cycle
        disp(2'd0, 3'd0, 4'hF, 16'd5, 4'hF, 16'd7, 4'd2);
        chk("t1_valid", int'(issue_valid), 1);
        chk("t1_avail", int'(available), 3'b110);
        expect_issue(3'd0, 16'd5, 16'd7, 4'd2, 2'd0);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("t1_avail_after", int'(available), 7);
        chk("t1_valid_after", int'(issue_valid), 0);

        // CDB wake-up, non-matching tag first
        disp(2'd1, 3'd1, 4'd4, 16'd0, 4'hF, 16'd1, 4'd3);
        chk("t2_wait", int'(issue_valid), 0);
        cdb_valid = 1'b1; cdb_rob_id = 4'd5; cdb_value = 16'h9999;
        tick();
        chk("t2_tag5", int'(issue_valid), 0);
        cdb_rob_id = 4'd4; cdb_value = 16'h1234;
        chk("t2_bcast_cycle", int'(issue_valid), 0);
        tick();
        cdb_valid = 1'b0;
        chk("t2_woken", int'(issue_valid), 1);
        chk("t2_vj", int'(issue_vj), 16'h1234);
        expect_issue(3'd1, 16'h1234, 16'd1, 4'd3, 2'd1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;

        // age order with stall
        disp(2'd2, 3'd2, 4'hF, 16'd10, 4'hF, 16'd20, 4'd4);
        disp(2'd0, 3'd3, 4'hF, 16'd30, 4'hF, 16'd40, 4'd5);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_idx", int'(issue_idx), 2);
            chk("t3_hold_vld", int'(issue_valid), 1);
            tick();
        end
        expect_issue(3'd2, 16'd10, 16'd20, 4'd4, 2'd2);
        expect_issue(3'd3, 16'd30, 16'd40, 4'd5, 2'd0);
        issue_ready = 1'b1;
        tick();
        chk("t3_next_idx", int'(issue_idx), 0);
        tick();
        issue_ready = 1'b0;
        chk("t3_avail", int'(available), 7);

        // same-cycle CDB forward into dispatch
        cdb_valid = 1'b1; cdb_rob_id = 4'd6; cdb_value = 16'hBEEF;
        disp(2'd1, 3'd4, 4'hF, 16'd9, 4'd6, 16'd0, 4'd7);
        cdb_valid = 1'b0;
        chk("t4_valid", int'(issue_valid), 1);
        chk("t4_vk", int'(issue_vk), 16'hBEEF);
        expect_issue(3'd4, 16'd9, 16'hBEEF, 4'd7, 2'd1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;

        // out-of-range slot is ignored
        disp(2'd3, 3'd1, 4'hF, 16'd1, 4'hF, 16'd1, 4'd9);
        chk("t5_oob_avail", int'(available), 7);
        chk("t5_oob_valid", int'(issue_valid), 0);

        // fill, redispatch to busy slot, flush
        disp(2'd0, 3'd1, 4'd3, 16'd0, 4'hF, 16'd1, 4'd10);
        disp(2'd1, 3'd1, 4'd3, 16'd0, 4'hF, 16'd2, 4'd11);
        disp(2'd2, 3'd1, 4'd3, 16'd0, 4'hF, 16'd3, 4'd12);
        disp(2'd1, 3'd5, 4'hF, 16'd1, 4'hF, 16'd1, 4'd13);
        chk("t5_full_avail", int'(available), 0);
        chk("t5_busy_ign", int'(issue_valid), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_avail", int'(available), 7);
        chk("t5_flush_vld", int'(issue_valid), 0);
        tick();
        chk("t5_flush_vld2", int'(issue_valid), 0);

        // async reset while stalled
        disp(2'd0, 3'd6, 4'hF, 16'd1, 4'hF, 16'd2, 4'd8);
        chk("t6_pre_vld", int'(issue_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", int'(issue_valid), 0);
        chk("t6_rst_avail", int'(available), 7);
        #2 rst_n = 1'b1;
        tick();
        tick();

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rs_bank.md
Name: alu_rs_bank

Overview:
Bank of ALU reservation stations on the receiving end of the dispatch interface driven by the decode stage. Accepts one dispatched operation per cycle into a decoder-selected slot and reports per-slot availability back to decode. Snoops the common data bus (CDB) to resolve pending operands. Issues the oldest fully-ready operation to the ALU over a valid/ready handshake.

Parameters:
NUM_ENTRIES, 3, number of station slots (1..8)
ROB_ID_W, 4, ROB tag width; all-ones tag = no dependency (invalid)
OP_W, 3, ALU opcode width
WORD_W, 16, operand width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
flush  in  1  synchronous squash of all slots (mispredict recovery)
disp_valid  in  1  dispatch request
disp_idx  in  clog2(NUM_ENTRIES)  target slot, chosen by decode
disp_op  in  OP_W  ALU operation
disp_qj, disp_qk  in  ROB_ID_W  source tags; all-ones = value present
disp_vj, disp_vk  in  WORD_W  source values, valid when tag invalid
disp_dest  in  ROB_ID_W  ROB entry receiving the result
available  out  NUM_ENTRIES  bit i = slot i free
cdb_valid  in  1  CDB broadcast valid
cdb_rob_id  in  ROB_ID_W  broadcasting tag
cdb_value  in  WORD_W  broadcast value
issue_valid  out  1  an operation is presented to the ALU
issue_ready  in  1  ALU accepts this cycle
issue_op  out  OP_W  issued operation
issue_vj, issue_vk  out  WORD_W  issued operands
issue_dest  out  ROB_ID_W  issued destination tag
issue_idx  out  clog2(NUM_ENTRIES)  slot being issued

Behaviour:
- Per-slot state: busy, op, qj, qk, vj, vk, dest. Pairwise age matrix older[i][j] (1 = slot i dispatched before slot j).
- Reset (async, rst_n low): all busy=0, all tags=invalid, age matrix cleared. available = all ones, issue_valid = 0, issue_* data = 0.
- available[i] = ~busy[i] from registered state only. A slot freed by issue at edge N is visible as available after edge N, not in the same cycle.
- Dispatch: on edge with disp_valid && !busy[disp_idx], load the slot and set busy. older[disp_idx][*] = 0; older[*][disp_idx] = 1 for every other busy slot.
- Dispatch to a busy slot, or disp_idx >= NUM_ENTRIES: ignored, state unchanged.
- CDB capture: each edge with cdb_valid, every busy slot with qj == cdb_rob_id and qj != invalid loads vj = cdb_value and sets qj = invalid. qk is handled identically.
- Same-cycle forward: if dispatch and CDB coincide and disp_qj/disp_qk match cdb_rob_id, the slot is written with the CDB value and an invalid tag, so the broadcast is not lost.
- An invalid CDB tag (all ones) never matches.
- Ready[i] = busy && qj invalid && qk invalid, from registered state.
- Issue selection: oldest ready slot, i.e. the ready slot with no older ready slot. issue_valid = |ready. issue_* are combinational from the selected slot.
- Latency: an operation dispatched with both operands present can issue the next cycle. A CDB wake-up makes the slot ready the cycle after the broadcast. No same-cycle CDB-to-issue bypass.
- Handshake: on an edge with issue_valid && issue_ready, the selected slot's busy clears and its age row and column clear.
- While issue_ready is low, the selected slot is held. issue_* may change only if an older slot becomes ready.
- Simultaneous issue and dispatch to different slots: both take effect. Dispatch to the slot being issued is ignored, since that slot still reads busy.
- flush: on edge, all busy=0 and the age matrix is cleared. It overrides dispatch, CDB capture and issue in that cycle. issue_valid falls the following cycle.
- rst_n asserted mid-operation: immediate return to the reset state, regardless of handshake.

Test Plan:
- Reset, then dispatch slot0 add, qj=qk=0xF, vj=5, vk=7, dest=2 -> next cycle issue_valid=1, op=add, vj=5, vk=7, dest=2. With issue_ready=1, available returns to 3'b111 after that edge.
- Dispatch slot1 with qj=4, vk=1; then CDB tag 4, value 0x1234 -> issue_valid=0 in the broadcast cycle; next cycle issue_vj=0x1234. A CDB with tag 5 leaves the slot waiting.
- Dispatch slot2, then slot0, both ready, issue_ready=0 for 3 cycles -> issue_idx=2 held stable. After accept, issue_idx=0.
- Dispatch with disp_qk=6 while CDB broadcasts tag 6, value 0xBEEF -> slot captured with vk=0xBEEF; issues next cycle.
- Fill all 3 slots with qj=3 (pending), then dispatch to slot1 again -> ignored, available=0. Flush -> available=3'b111 next cycle, issue_valid stays 0.
- Assert rst_n low while issue_valid=1 and issue_ready=0 -> issue_valid=0 immediately, available all ones.
